// File: rtl/mips_datapath_memory_access.sv
// MEM-stage load/store unit with an internal byte-addressable word store and handshaked requests.
// Optional feature macro: MIPS_DATAPATH_MEMORY_UNALIGNED_EN (split misaligned accesses into two beats).
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | first (or only) memory beat, counting down the latency
// WAIT2 | second beat of a split misaligned access (feature macro only)
// DONE  | one-cycle response pulse
module mips_datapath_memory_access #(
   parameter int ADDR_L  = 64,
   parameter int ADDR_W  = $clog2(ADDR_L),
   parameter int LATENCY = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_size_i,
   input  logic              req_signed_i,
   input  logic              req_write_i,
   input  logic [ADDR_W+1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              resp_valid_o,
   output logic              resp_err_o,
   output logic [31:0]       resp_rdata_o,
   output logic              stall_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
`ifdef MIPS_DATAPATH_MEMORY_UNALIGNED_EN
      S_WAIT2 = 2'd2,
`endif
      S_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [1:0]          size_q;
   logic                signed_q;
   logic                write_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [31:0]         mem_q [ADDR_L];

   logic                accept;
   logic [1:0]          lane;
   logic [ADDR_W-1:0]   idx;
   logic [ADDR_W-1:0]   mem_idx;
   logic [2:0]          nbytes;
   logic [7:0]          be64;
   logic [63:0]         wd64;
   logic [63:0]         data64;
   logic [31:0]         shifted;
   logic [31:0]         load_val;
   logic [31:0]         rd_word;
   logic [31:0]         lo_w;
   logic                beat2;
   logic                commit;
   logic                mem_we;
   logic [3:0]          wr_be;
   logic [31:0]         wr_data;

   function automatic logic misalign(input logic [1:0] sz, input logic [1:0] a);
      return ((sz == 2'd2) && a[0]) || ((sz == 2'd3) && (a != 2'd0));
   endfunction

   assign accept = req_valid_i && (state_q == S_IDLE);
   assign lane   = addr_q[1:0];
   assign idx    = addr_q[ADDR_W+1:2];

`ifdef MIPS_DATAPATH_MEMORY_UNALIGNED_EN
   logic [ADDR_W-1:0] idx_nxt;
   logic [31:0]       lo_q;
   logic              split;
   assign idx_nxt = (idx == ADDR_W'(ADDR_L - 1)) ? '0 : idx + ADDR_W'(1);
   assign beat2   = (state_q == S_WAIT2);
   assign split   = misalign(size_q, lane);
   assign lo_w    = lo_q;
   assign mem_idx = beat2 ? idx_nxt : idx;
`else
   assign beat2   = 1'b0;
   assign lo_w    = '0;
   assign mem_idx = idx;
`endif

   always_comb begin
      unique case (size_q)
         2'd1:    nbytes = 3'd1;
         2'd2:    nbytes = 3'd2;
         2'd3:    nbytes = 3'd4;
         default: nbytes = 3'd0;
      endcase
   end

   // Byte enables over an 8-byte window so a split access covers word n and n+1 uniformly.
   always_comb begin
      be64 = '0;
      for (int j = 0; j < 8; j++) begin
         be64[j] = (4'(j) >= {2'b00, lane}) && (4'(j) < ({2'b00, lane} + {1'b0, nbytes}));
      end
   end

   assign wd64    = {32'h0, wdata_q} << {lane, 3'b000};
   assign wr_be   = beat2 ? be64[7:4] : be64[3:0];
   assign wr_data = beat2 ? wd64[63:32] : wd64[31:0];
   assign rd_word = mem_q[mem_idx];
   assign commit  = ((state_q == S_WAIT) || beat2) && (cnt_q == 3'd0);
   assign mem_we  = commit && write_q;

   assign data64  = {beat2 ? rd_word : 32'h0, beat2 ? lo_w : rd_word};
   assign shifted = 32'(data64 >> {lane, 3'b000});

   always_comb begin
      unique case (size_q)
         2'd1:    load_val = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'h0, shifted[7:0]};
         2'd2:    load_val = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                      : {16'h0, shifted[15:0]};
         2'd3:    load_val = shifted;
         default: load_val = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               rdata_d = '0;
               err_d   = 1'b0;
               if (req_size_i == 2'd0) begin
                  state_d = S_DONE;
`ifndef MIPS_DATAPATH_MEMORY_UNALIGNED_EN
               end else if (misalign(req_size_i, req_addr_i[1:0])) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
`endif
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               state_d = S_DONE;
               if (!write_q) rdata_d = load_val;
`ifdef MIPS_DATAPATH_MEMORY_UNALIGNED_EN
               if (split) begin
                  state_d = S_WAIT2;
                  cnt_d   = CNT_INIT;
                  rdata_d = rdata_q;
               end
`endif
            end
         end
`ifdef MIPS_DATAPATH_MEMORY_UNALIGNED_EN
         S_WAIT2: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               state_d = S_DONE;
               if (!write_q) rdata_d = load_val;
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            write_q  <= req_write_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
         end
      end
   end

`ifdef MIPS_DATAPATH_MEMORY_UNALIGNED_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lo_q <= '0;
      end else if (commit && !beat2) begin
         lo_q <= rd_word;
      end
   end
`endif

   // Storage is deliberately not reset; an async reset drops state_q to IDLE so mem_we falls at once.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem_q[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign req_ready_o  = (state_q == S_IDLE);
   assign stall_o      = (state_q != S_IDLE);
   assign resp_valid_o = (state_q == S_DONE);
   assign resp_err_o   = err_q;
   assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_mips_datapath_memory_access.sv
// Randomized self-checking bench for mips_datapath_memory_access against a byte-array reference model.
module tb_mips_datapath_memory_access;

   localparam int ADDR_L = 64;
   localparam int ADDR_W = 6;
   localparam int LAT    = 4;
   localparam int NBYTES = ADDR_L * 4;
`ifdef MIPS_DATAPATH_MEMORY_UNALIGNED_EN
   localparam bit UNAL = 1'b1;
`else
   localparam bit UNAL = 1'b0;
`endif

   logic              clk_sys = 1'b0;
   logic              rst_n   = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0]        req_size = '0;
   logic              req_signed = 1'b0;
   logic              req_write = 1'b0;
   logic [ADDR_W+1:0] req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic              resp_valid;
   logic              resp_err;
   logic [31:0]       resp_rdata;
   logic              stall;

   int checks = 0;
   int errors = 0;
   logic [7:0] mem_m [NBYTES];

   always #5 clk_sys = ~clk_sys;

   mips_datapath_memory_access #(.ADDR_L(ADDR_L), .LATENCY(LAT)) dut (
      .clk_i        (clk_sys),
      .rst_n_i      (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_size_i   (req_size),
      .req_signed_i (req_signed),
      .req_write_i  (req_write),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (resp_valid),
      .resp_err_o   (resp_err),
      .resp_rdata_o (resp_rdata),
      .stall_o      (stall)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: storage as a flat byte array; a split access simply walks consecutive bytes.
   task automatic model_access(input logic [1:0] sz, input logic sg, input logic wr,
                               input logic [7:0] a, input logic [31:0] wd,
                               output logic [31:0] rd, output logic er, output int lat);
      int n;
      bit mis;
      n   = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : (sz == 2'd3) ? 4 : 0;
      mis = (n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0);
      rd  = 32'h0;
      er  = 1'b0;
      if (n == 0) begin
         lat = 1;
      end else if (mis && !UNAL) begin
         er  = 1'b1;
         lat = 1;
      end else begin
         lat = mis ? 2 * LAT + 1 : LAT + 1;
         for (int i = 0; i < n; i++) begin
            if (wr) mem_m[(a + i) % NBYTES] = wd[8*i +: 8];
            else    rd[8*i +: 8] = mem_m[(a + i) % NBYTES];
         end
         if (!wr && sg && n < 4 && rd[8*n-1]) rd = rd | ~((32'h1 << (8 * n)) - 32'h1);
      end
   endtask

   task automatic drive_req(input logic [1:0] sz, input logic sg, input logic wr,
                            input logic [7:0] a, input logic [31:0] wd);
      req_size = sz; req_signed = sg; req_write = wr; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk_sys);
      #1 req_valid = 1'b0;
   endtask

   task automatic do_access(input string tag, input logic [1:0] sz, input logic sg, input logic wr,
                            input logic [7:0] a, input logic [31:0] wd);
      logic [31:0] exp_rd;
      logic        exp_er;
      int          exp_lat;
      int          n;
      bit          got;
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (!req_ready && n < 40);
      if (!req_ready) begin
         check_eq({tag, "_ready_timeout"}, 32'(req_ready), 32'h1);
         return;
      end
      model_access(sz, sg, wr, a, wd, exp_rd, exp_er, exp_lat);
      drive_req(sz, sg, wr, a, wd);
      n   = 0;
      got = 0;
      while (!got && n < 40) begin
         @(negedge clk_sys);
         n++;
         if (resp_valid) got = 1;
      end
      check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
      if (got) begin
         check_eq({tag, "_rdata"}, resp_rdata, exp_rd);
         check_eq({tag, "_err"}, 32'(resp_err), 32'(exp_er));
         @(negedge clk_sys);
         check_eq({tag, "_pulse"}, 32'(resp_valid), 32'h0);
         check_eq({tag, "_hold"}, resp_rdata, exp_rd);
      end
   endtask

   initial begin
      logic [31:0] d_rd;
      logic        d_er;
      int          d_lat;
      int          cyc, last, st, nacc, n;

      repeat (2) @(negedge clk_sys);
      check_eq("rst_ready", 32'(req_ready), 32'h1);
      check_eq("rst_stall", 32'(stall), 32'h0);
      check_eq("rst_valid", 32'(resp_valid), 32'h0);
      check_eq("rst_err", 32'(resp_err), 32'h0);
      check_eq("rst_rdata", resp_rdata, 32'h0);
      rst_n = 1'b1;

      for (int w = 0; w < ADDR_L; w++) do_access("pre", 2'd3, 1'b0, 1'b1, 8'(w * 4), $urandom);

      // Byte lane and sign extension
      do_access("st_b07", 2'd1, 1'b0, 1'b1, 8'h07, 32'h1234_5680);
      do_access("ld_b07s", 2'd1, 1'b1, 1'b0, 8'h07, 32'h0);
      check_eq("ld_b07s_const", resp_rdata, 32'hFFFF_FF80);
      do_access("ld_b07u", 2'd1, 1'b0, 1'b0, 8'h07, 32'h0);
      check_eq("ld_b07u_const", resp_rdata, 32'h0000_0080);
      do_access("ld_w04", 2'd3, 1'b0, 1'b0, 8'h04, 32'h0);
      check_eq("ld_w04_top", 32'(resp_rdata[31:24]), 32'h80);

      // Half lanes
      do_access("st_h22", 2'd2, 1'b0, 1'b1, 8'h22, 32'hFFFF_1234);
      do_access("ld_w20", 2'd3, 1'b0, 1'b0, 8'h20, 32'h0);
      check_eq("ld_w20_hi", 32'(resp_rdata[31:16]), 32'h1234);
      do_access("ld_h22s", 2'd2, 1'b1, 1'b0, 8'h22, 32'h0);

      // Misaligned word, then a neighbouring store that must trap (macro off) or split
      do_access("mis_ld05", 2'd3, 1'b0, 1'b0, 8'h05, 32'h0);
      do_access("mis_st05", 2'd3, 1'b0, 1'b1, 8'h05, 32'h5555_AAAA);
      do_access("ld_w04b", 2'd3, 1'b0, 1'b0, 8'h04, 32'h0);
      do_access("ld_w08b", 2'd3, 1'b0, 1'b0, 8'h08, 32'h0);
      do_access("none", 2'd0, 1'b0, 1'b1, 8'h08, 32'hFFFF_FFFF);
      do_access("ld_w08c", 2'd3, 1'b0, 1'b0, 8'h08, 32'h0);

`ifdef MIPS_DATAPATH_MEMORY_UNALIGNED_EN
      do_access("sp_st", 2'd3, 1'b0, 1'b1, 8'hFE, 32'hAABB_CCDD);
      do_access("sp_w63", 2'd3, 1'b0, 1'b0, 8'hFC, 32'h0);
      check_eq("sp_w63_hi", 32'(resp_rdata[31:16]), 32'hCCDD);
      do_access("sp_w0", 2'd3, 1'b0, 1'b0, 8'h00, 32'h0);
      check_eq("sp_w0_lo", 32'(resp_rdata[15:0]), 32'hAABB);
      do_access("sp_ld", 2'd3, 1'b0, 1'b0, 8'hFE, 32'h0);
      check_eq("sp_ld_const", resp_rdata, 32'hAABB_CCDD);
      do_access("sp_h3", 2'd2, 1'b1, 1'b0, 8'h13, 32'h0);
`endif

      // Reset during WAIT of a store: the store must never land
      @(negedge clk_sys);
      drive_req(2'd3, 1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF);
      repeat (2) @(negedge clk_sys);
      rst_n = 1'b0;
      #1;
      check_eq("abort_ready", 32'(req_ready), 32'h1);
      check_eq("abort_stall", 32'(stall), 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_sys);
         check_eq("abort_valid", 32'(resp_valid), 32'h0);
      end
      rst_n = 1'b1;
      do_access("abort_ld", 2'd3, 1'b0, 1'b0, 8'h10, 32'h0);

      // Reset after the commit edge: the store stays
      @(negedge clk_sys);
      model_access(2'd3, 1'b0, 1'b1, 8'h14, 32'h0BAD_F00D, d_rd, d_er, d_lat);
      drive_req(2'd3, 1'b0, 1'b1, 8'h14, 32'h0BAD_F00D);
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (!resp_valid && n < 40);
      check_eq("late_rst_seen", 32'(resp_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      check_eq("late_rst_valid", 32'(resp_valid), 32'h0);
      @(negedge clk_sys);
      rst_n = 1'b1;
      do_access("late_ld", 2'd3, 1'b0, 1'b0, 8'h14, 32'h0);

      // Back-pressure: valid held high, one acceptance per LAT+2 cycles
      @(negedge clk_sys);
      req_size = 2'd3; req_signed = 1'b0; req_write = 1'b0; req_addr = 8'h20; req_wdata = '0;
      req_valid = 1'b1;
      cyc = 0; last = -1; st = 0; nacc = 0;
      while (nacc < 6 && cyc < 200) begin
         if (stall) st++;
         if (req_ready) begin
            check_eq("bp_idle_stall", 32'(stall), 32'h0);
            if (last >= 0) begin
               check_eq("bp_gap", 32'(cyc - last), 32'(LAT + 2));
               check_eq("bp_stall_cycles", 32'(st), 32'(LAT + 1));
            end
            last = cyc;
            st   = 0;
            nacc++;
         end
         @(negedge clk_sys);
         cyc++;
      end
      check_eq("bp_accepts", 32'(nacc), 32'h6);
      req_valid = 1'b0;
      repeat (LAT + 3) @(negedge clk_sys);

      for (int k = 0; k < 120; k++) begin
         do_access("rnd", 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   8'($urandom), $urandom);
      end
      for (int w = 0; w < 8; w++) do_access("final", 2'd3, 1'b0, 1'b0, 8'(w * 4), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
